// File: rtl/ticket_fare_fsm.sv
// Ticket vending controller: validates a route request, computes the fare, collects coins,
// dispenses tickets one pulse at a time, and returns change or a refund on cancel.
module ticket_fare_fsm #(
   parameter int unsigned STATIONS    = 8,
   parameter int unsigned STN_W       = 3,
   parameter int unsigned MAX_TICKETS = 7,
   parameter int unsigned BASE_FARE   = 5,
   parameter int unsigned STEP_FARE   = 5,
   parameter int unsigned MONEY_W     = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [STN_W-1:0]   origin,
   input  logic [STN_W-1:0]   destination,
   input  logic [2:0]         howManyTicket,
   input  logic               coinValid,
   input  logic [5:0]         coin,
   input  logic               cancel,
   output logic [MONEY_W-1:0] costOfTicket,
   output logic [MONEY_W-1:0] moneyToPay,
   output logic [MONEY_W-1:0] totalMoney,
   output logic               ticketOut,
   output logic               changeValid,
   output logic [MONEY_W-1:0] changeOut,
   output logic               refund,
   output logic               coinReject,
   output logic               error,
   output logic               busy
);

   localparam int unsigned CNT_W = 3;

   localparam logic [2:0] st_idle     = 3'd0;
   localparam logic [2:0] st_pay      = 3'd1;
   localparam logic [2:0] st_dispense = 3'd2;
   localparam logic [2:0] st_change   = 3'd3;
   localparam logic [2:0] st_refund   = 3'd4;

   localparam logic [STN_W:0] stn_lim = (STN_W+1)'(STATIONS);
   localparam logic [CNT_W-1:0] cnt_max = CNT_W'(MAX_TICKETS);

   logic [2:0]         state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [MONEY_W-1:0] cost_q, cost_n;
   logic [MONEY_W-1:0] total_q, total_n;
   logic [MONEY_W-1:0] topay_q, topay_n;
   logic [MONEY_W-1:0] chg_out_q, chg_out_n;
   logic               ticket_q, ticket_n;
   logic               chg_valid_q, chg_valid_n;
   logic               refund_q, refund_n;
   logic               coin_rej_q, coin_rej_n;
   logic               err_q, err_n;
   logic               busy_q, busy_n;

   logic [STN_W-1:0]   dist_c;
   logic [MONEY_W-1:0] fare_c;
   logic               req_ok_c;
   logic               coin_ok_c;
   logic [MONEY_W-1:0] pay_total_c;

   // Request decode and fare arithmetic
   always_comb begin
      dist_c    = (origin > destination) ? (origin - destination) : (destination - origin);
      fare_c    = MONEY_W'(howManyTicket) *
                  (MONEY_W'(BASE_FARE) + MONEY_W'(STEP_FARE) * MONEY_W'(dist_c));
      req_ok_c  = (origin != destination) &&
                  ({1'b0, origin} < stn_lim) && ({1'b0, destination} < stn_lim) &&
                  (howManyTicket != 3'd0) && (howManyTicket <= cnt_max);
      coin_ok_c = (coin == 6'd1) || (coin == 6'd5) || (coin == 6'd10) || (coin == 6'd50);
   end

   // Next state and next registered outputs
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      cost_n      = cost_q;
      total_n     = total_q;
      topay_n     = topay_q;
      chg_out_n   = chg_out_q;
      ticket_n    = 1'b0;
      chg_valid_n = 1'b0;
      refund_n    = 1'b0;
      coin_rej_n  = 1'b0;
      err_n       = 1'b0;
      pay_total_c = total_q;

      case (state_q)
         st_idle: begin
            if (start) begin
               if (req_ok_c) begin
                  cnt_n   = howManyTicket;
                  cost_n  = fare_c;
                  total_n = '0;
                  topay_n = fare_c;
                  state_n = st_pay;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         st_pay: begin
            if (coinValid) begin
               if (coin_ok_c) pay_total_c = total_q + MONEY_W'(coin);
               else           coin_rej_n  = 1'b1;
            end
            total_n = pay_total_c;
            topay_n = (pay_total_c >= cost_q) ? '0 : (cost_q - pay_total_c);
            // Cancel wins over a paying coin; that coin is still refunded
            if (cancel) begin
               state_n     = st_refund;
               chg_valid_n = 1'b1;
               chg_out_n   = pay_total_c;
               refund_n    = 1'b1;
            end else if (pay_total_c >= cost_q) begin
               state_n  = st_dispense;
               ticket_n = 1'b1;
            end
         end
         st_dispense: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_n     = st_change;
               chg_valid_n = 1'b1;
               chg_out_n   = total_q - cost_q;
            end else begin
               cnt_n    = cnt_q - CNT_W'(1);
               ticket_n = 1'b1;
            end
         end
         st_change: state_n = st_idle;
         st_refund: state_n = st_idle;
         default:   state_n = st_idle;
      endcase

      busy_n = (state_n != st_idle);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= st_idle;
         cnt_q       <= '0;
         cost_q      <= '0;
         total_q     <= '0;
         topay_q     <= '0;
         chg_out_q   <= '0;
         ticket_q    <= 1'b0;
         chg_valid_q <= 1'b0;
         refund_q    <= 1'b0;
         coin_rej_q  <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         cost_q      <= cost_n;
         total_q     <= total_n;
         topay_q     <= topay_n;
         chg_out_q   <= chg_out_n;
         ticket_q    <= ticket_n;
         chg_valid_q <= chg_valid_n;
         refund_q    <= refund_n;
         coin_rej_q  <= coin_rej_n;
         err_q       <= err_n;
         busy_q      <= busy_n;
      end
   end

   assign costOfTicket = cost_q;
   assign moneyToPay   = topay_q;
   assign totalMoney   = total_q;
   assign ticketOut    = ticket_q;
   assign changeValid  = chg_valid_q;
   assign changeOut    = chg_out_q;
   assign refund       = refund_q;
   assign coinReject   = coin_rej_q;
   assign error        = err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_ticket_fare_fsm.sv
// Directed bench for ticket_fare_fsm with hand-computed fares, balances and change.
module tb_ticket_fare_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] origin;
   logic [2:0] destination;
   logic [2:0] howManyTicket;
   logic       coinValid;
   logic [5:0] coin;
   logic       cancel;
   logic [9:0] costOfTicket;
   logic [9:0] moneyToPay;
   logic [9:0] totalMoney;
   logic       ticketOut;
   logic       changeValid;
   logic [9:0] changeOut;
   logic       refund;
   logic       coinReject;
   logic       error;
   logic       busy;

   int checks = 0;
   int errors = 0;

   ticket_fare_fsm dut (
      .clk(clk), .reset(reset), .start(start), .origin(origin), .destination(destination),
      .howManyTicket(howManyTicket), .coinValid(coinValid), .coin(coin), .cancel(cancel),
      .costOfTicket(costOfTicket), .moneyToPay(moneyToPay), .totalMoney(totalMoney),
      .ticketOut(ticketOut), .changeValid(changeValid), .changeOut(changeOut),
      .refund(refund), .coinReject(coinReject), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [2:0] o, input logic [2:0] d, input logic [2:0] n);
      origin = o; destination = d; howManyTicket = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_coin(input logic [5:0] c);
      coin = c; coinValid = 1'b1;
      tick();
      coinValid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; origin = '0; destination = '0; howManyTicket = '0;
      coinValid = 1'b0; coin = '0; cancel = 1'b0;
      #3;
      checks++; if (costOfTicket !== 10'd0) begin errors++; $display("FAIL reset_cost got %0d exp 0", costOfTicket); end
      checks++; if (totalMoney !== 10'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", totalMoney); end
      checks++; if ({busy, ticketOut, changeValid, refund, coinReject, error} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {busy, ticketOut, changeValid, refund, coinReject, error}); end
      checks++; if ({moneyToPay, changeOut} !== 20'd0) begin errors++; $display("FAIL reset_money got %0d/%0d exp 0/0", moneyToPay, changeOut); end
      tick(); tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_normal();
      do_start(3'd2, 3'd5, 3'd2);
      checks++; if (costOfTicket !== 10'd40) begin errors++; $display("FAIL norm_cost got %0d exp 40", costOfTicket); end
      checks++; if (moneyToPay !== 10'd40) begin errors++; $display("FAIL norm_topay0 got %0d exp 40", moneyToPay); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL norm_busy got %b exp 1", busy); end
      do_coin(6'd10);
      checks++; if (totalMoney !== 10'd10 || moneyToPay !== 10'd30) begin errors++; $display("FAIL norm_coin1 got %0d/%0d exp 10/30", totalMoney, moneyToPay); end
      do_coin(6'd10);
      checks++; if (totalMoney !== 10'd20 || moneyToPay !== 10'd20) begin errors++; $display("FAIL norm_coin2 got %0d/%0d exp 20/20", totalMoney, moneyToPay); end
      do_coin(6'd50);
      checks++; if (totalMoney !== 10'd70 || moneyToPay !== 10'd0) begin errors++; $display("FAIL norm_coin3 got %0d/%0d exp 70/0", totalMoney, moneyToPay); end
      checks++; if (ticketOut !== 1'b1) begin errors++; $display("FAIL norm_ticket1 got %b exp 1", ticketOut); end
      // A bad coin strobed while dispensing is neither counted nor rejected
      do_coin(6'd7);
      checks++; if (ticketOut !== 1'b1) begin errors++; $display("FAIL norm_ticket2 got %b exp 1", ticketOut); end
      checks++; if (coinReject !== 1'b0 || totalMoney !== 10'd70) begin errors++; $display("FAIL norm_disp_coin got %b/%0d exp 0/70", coinReject, totalMoney); end
      tick();
      checks++; if (ticketOut !== 1'b0) begin errors++; $display("FAIL norm_ticket3 got %b exp 0", ticketOut); end
      checks++; if (changeValid !== 1'b1 || changeOut !== 10'd30 || refund !== 1'b0) begin errors++; $display("FAIL norm_change got %b/%0d/%b exp 1/30/0", changeValid, changeOut, refund); end
      tick();
      checks++; if (busy !== 1'b0 || changeValid !== 1'b0) begin errors++; $display("FAIL norm_idle got %b/%b exp 0/0", busy, changeValid); end
   endtask

   task automatic test_cancel();
      do_start(3'd5, 3'd1, 3'd4);
      checks++; if (costOfTicket !== 10'd100 || totalMoney !== 10'd0) begin errors++; $display("FAIL canc_cost got %0d/%0d exp 100/0", costOfTicket, totalMoney); end
      do_coin(6'd50);
      checks++; if (moneyToPay !== 10'd50) begin errors++; $display("FAIL canc_topay1 got %0d exp 50", moneyToPay); end
      do_coin(6'd10);
      checks++; if (moneyToPay !== 10'd40) begin errors++; $display("FAIL canc_topay2 got %0d exp 40", moneyToPay); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (changeValid !== 1'b1 || changeOut !== 10'd60 || refund !== 1'b1) begin errors++; $display("FAIL canc_refund got %b/%0d/%b exp 1/60/1", changeValid, changeOut, refund); end
      checks++; if (ticketOut !== 1'b0) begin errors++; $display("FAIL canc_ticket got %b exp 0", ticketOut); end
      tick();
      checks++; if (busy !== 1'b0 || refund !== 1'b0) begin errors++; $display("FAIL canc_idle got %b/%b exp 0/0", busy, refund); end
   endtask

   task automatic test_exact();
      do_start(3'd3, 3'd5, 3'd1);
      checks++; if (costOfTicket !== 10'd15) begin errors++; $display("FAIL exact_cost got %0d exp 15", costOfTicket); end
      do_coin(6'd10);
      checks++; if (moneyToPay !== 10'd5 || ticketOut !== 1'b0) begin errors++; $display("FAIL exact_coin1 got %0d/%b exp 5/0", moneyToPay, ticketOut); end
      do_coin(6'd5);
      checks++; if (ticketOut !== 1'b1 || totalMoney !== 10'd15) begin errors++; $display("FAIL exact_ticket got %b/%0d exp 1/15", ticketOut, totalMoney); end
      tick();
      checks++; if (changeValid !== 1'b1 || changeOut !== 10'd0 || ticketOut !== 1'b0) begin errors++; $display("FAIL exact_change got %b/%0d/%b exp 1/0/0", changeValid, changeOut, ticketOut); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exact_idle got %b exp 0", busy); end
   endtask

   task automatic test_error();
      do_start(3'd3, 3'd3, 3'd2);
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_same got %b/%b exp 1/0", error, busy); end
      tick();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", error); end
      do_start(3'd1, 3'd4, 3'd0);
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_zero got %b/%b exp 1/0", error, busy); end
      checks++; if (costOfTicket !== 10'd15) begin errors++; $display("FAIL err_hold got %0d exp 15", costOfTicket); end
      // Coins in IDLE are ignored
      do_coin(6'd50);
      checks++; if (totalMoney !== 10'd15 || coinReject !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_idle_coin got %0d/%b/%b exp 15/0/0", totalMoney, coinReject, busy); end
   endtask

   task automatic test_reject_cancel();
      do_start(3'd0, 3'd1, 3'd1);
      checks++; if (costOfTicket !== 10'd10) begin errors++; $display("FAIL rej_cost got %0d exp 10", costOfTicket); end
      do_coin(6'd7);
      checks++; if (coinReject !== 1'b1 || totalMoney !== 10'd0) begin errors++; $display("FAIL rej_coin got %b/%0d exp 1/0", coinReject, totalMoney); end
      cancel = 1'b1; coin = 6'd5; coinValid = 1'b1;
      tick();
      cancel = 1'b0; coinValid = 1'b0;
      checks++; if (changeValid !== 1'b1 || changeOut !== 10'd5 || refund !== 1'b1) begin errors++; $display("FAIL rej_refund got %b/%0d/%b exp 1/5/1", changeValid, changeOut, refund); end
      checks++; if (totalMoney !== 10'd5 || coinReject !== 1'b0) begin errors++; $display("FAIL rej_total got %0d/%b exp 5/0", totalMoney, coinReject); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_idle got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid();
      do_start(3'd0, 3'd7, 3'd7);
      checks++; if (costOfTicket !== 10'd280) begin errors++; $display("FAIL mid_cost got %0d exp 280", costOfTicket); end
      for (int i = 0; i < 6; i++) do_coin(6'd50);
      checks++; if (ticketOut !== 1'b1 || totalMoney !== 10'd300) begin errors++; $display("FAIL mid_ticket1 got %b/%0d exp 1/300", ticketOut, totalMoney); end
      tick(); tick();
      checks++; if (ticketOut !== 1'b1) begin errors++; $display("FAIL mid_ticket3 got %b exp 1", ticketOut); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if ({busy, ticketOut, changeValid, refund, coinReject, error} !== 6'b0) begin errors++; $display("FAIL mid_flags got %b exp 000000", {busy, ticketOut, changeValid, refund, coinReject, error}); end
      checks++; if ({costOfTicket, totalMoney, moneyToPay, changeOut} !== 40'd0) begin errors++; $display("FAIL mid_money got %0d/%0d/%0d/%0d exp 0", costOfTicket, totalMoney, moneyToPay, changeOut); end
      tick();
      checks++; if (changeValid !== 1'b0 || ticketOut !== 1'b0) begin errors++; $display("FAIL mid_hold got %b/%b exp 0/0", changeValid, ticketOut); end
      reset = 1'b1;
      tick();
      do_start(3'd2, 3'd5, 3'd2);
      checks++; if (costOfTicket !== 10'd40 || busy !== 1'b1 || totalMoney !== 10'd0) begin errors++; $display("FAIL mid_restart got %0d/%b/%0d exp 40/1/0", costOfTicket, busy, totalMoney); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (refund !== 1'b1 || changeOut !== 10'd0) begin errors++; $display("FAIL mid_cancel got %b/%0d exp 1/0", refund, changeOut); end
      tick();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_cancel();
      test_exact();
      test_error();
      test_reject_cancel();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
